// File: rtl/hwce_sop_pkg.sv
// rtl/hwce_sop_pkg.sv - shared types, constants and output conversion for the HWCE sum-of-products stage
package hwce_sop_pkg;

  typedef enum logic {
    PREC_16 = 1'b0,
    PREC_8  = 1'b1
  } prec_e;

  // Activation byte -128 is mapped to -127 in packed 8-bit mode
  localparam logic [7:0] CLAMP_FROM = 8'h80;
  localparam logic [7:0] CLAMP_TO   = 8'h81;

  localparam int DEF_X_WIDTH   = 16;
  localparam int DEF_ACC_WIDTH = 48;
  localparam int DEF_OUT_WIDTH = 32;

  // Saturate value to the signed range of a width-bit field when sat is set;
  // caller keeps the low width bits of the result
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width, input bit sat);
    logic signed [63:0] hi_lim;
    logic signed [63:0] lo_lim;
    logic signed [63:0] res;
    hi_lim = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo_lim = -hi_lim - 64'sd1;
    res    = value;
    if (sat && (value > hi_lim)) res = hi_lim;
    if (sat && (value < lo_lim)) res = lo_lim;
    return res;
  endfunction

endpackage

// File: rtl/hwce_sop_acc_lane.sv
// rtl/hwce_sop_acc_lane.sv - one MAC lane: clamp, multiply pipeline, accumulators, output conversion (HWCE_SOP_ACC_SAT_EN selects saturation)
module hwce_sop_acc_lane
  import hwce_sop_pkg::*;
#(
  parameter int X_WIDTH   = DEF_X_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [X_WIDTH-1:0]   x,
  input  logic [X_WIDTH-1:0]   w,
  input  logic                 prod_valid,
  input  logic                 prod_first,
  input  logic                 out_load,
  input  prec_e                out_mode,
  output logic [OUT_WIDTH-1:0] y
);

  localparam int HA     = ACC_WIDTH / 2;
  localparam int OH     = OUT_WIDTH / 2;
  localparam int HI_LSB = (X_WIDTH >= 16) ? 8 : 0;
`ifdef HWCE_SOP_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic signed [2*X_WIDTH-1:0] xe, we, p16_c;
  logic signed [7:0]           xh, xl, wb;
  logic signed [15:0]          phi_c, plo_c;
  logic signed [2*X_WIDTH-1:0] p16_q [MUL_LAT];
  logic signed [15:0]          phi_q [MUL_LAT];
  logic signed [15:0]          plo_q [MUL_LAT];
  logic signed [ACC_WIDTH-1:0] acc16_q;
  logic signed [HA-1:0]        acc_hi_q, acc_lo_q;
  logic signed [63:0]          c16, chi, clo;
  logic [OUT_WIDTH-1:0]        y_next;

  // Operand clamp and both product forms for the first pipeline stage
  always_comb begin
    xe    = {{X_WIDTH{x[X_WIDTH-1]}}, x};
    we    = {{X_WIDTH{w[X_WIDTH-1]}}, w};
    p16_c = xe * we;
    xh    = (x[HI_LSB +: 8] == CLAMP_FROM) ? CLAMP_TO : x[HI_LSB +: 8];
    xl    = (x[7:0] == CLAMP_FROM) ? CLAMP_TO : x[7:0];
    wb    = w[7:0];
    phi_c = 16'(xh) * 16'(wb);
    plo_c = 16'(xl) * 16'(wb);
  end

  // Product pipeline; holds whenever the stage is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        p16_q[i] <= '0;
        phi_q[i] <= '0;
        plo_q[i] <= '0;
      end
    end else if (en) begin
      p16_q[0] <= p16_c;
      phi_q[0] <= phi_c;
      plo_q[0] <= plo_c;
      for (int i = 1; i < MUL_LAT; i++) begin
        p16_q[i] <= p16_q[i-1];
        phi_q[i] <= phi_q[i-1];
        plo_q[i] <= plo_q[i-1];
      end
    end
  end

  // Window accumulators: first tap loads, later taps add, all wrap at their width
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc16_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else if (en && prod_valid) begin
      if (prod_first) begin
        acc16_q  <= ACC_WIDTH'(p16_q[MUL_LAT-1]);
        acc_hi_q <= HA'(phi_q[MUL_LAT-1]);
        acc_lo_q <= HA'(plo_q[MUL_LAT-1]);
      end else begin
        acc16_q  <= acc16_q + ACC_WIDTH'(p16_q[MUL_LAT-1]);
        acc_hi_q <= acc_hi_q + HA'(phi_q[MUL_LAT-1]);
        acc_lo_q <= acc_lo_q + HA'(plo_q[MUL_LAT-1]);
      end
    end
  end

  // Output conversion of the accumulators into the lane result format
  always_comb begin
    c16    = sat_trunc(64'(acc16_q), OUT_WIDTH, SAT_EN);
    chi    = sat_trunc(64'(acc_hi_q), OH, SAT_EN);
    clo    = sat_trunc(64'(acc_lo_q), OH, SAT_EN);
    y_next = (out_mode == PREC_8) ? {OH'(chi), OH'(clo)} : OUT_WIDTH'(c16);
  end

  // Result register; clear leaves the last result visible
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (!clear && en && out_load) begin
      y <= y_next;
    end
  end

endmodule

// File: rtl/hwce_sop_acc.sv
// rtl/hwce_sop_acc.sv - NPX-lane sum-of-products accumulator with handshake (HWCE_SOP_ACC_SAT_EN enables output saturation)
module hwce_sop_acc
  import hwce_sop_pkg::*;
#(
  parameter int NPX       = 4,
  parameter int X_WIDTH   = DEF_X_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int MUL_LAT   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [7:0]               fs_fs,
  input  logic                     precision8,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NPX*X_WIDTH-1:0]   x_in,
  input  logic [NPX*X_WIDTH-1:0]   w_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NPX*OUT_WIDTH-1:0] y_out,
  output logic                     busy
);

  logic         adv, fire, first_tap, last_tap;
  logic [7:0]   cnt_q, win_fs_q, fs_req, fs_eff;
  prec_e        win_mode_q, mode_eff;
  logic [MUL_LAT-1:0] v_q, first_q, last_q;
  prec_e        mode_q [MUL_LAT];
  logic         acc_v_q, acc_last_q, out_valid_q;
  prec_e        acc_mode_q;

  // Handshake and per-beat window position; config comes from the pins only on a window's first tap
  always_comb begin
    adv       = !(out_valid_q && !out_ready);
    fire      = in_valid && adv;
    fs_req    = (fs_fs == 8'd0) ? 8'd1 : fs_fs;
    first_tap = (cnt_q == 8'd0);
    fs_eff    = first_tap ? fs_req : win_fs_q;
    mode_eff  = first_tap ? prec_e'(precision8) : win_mode_q;
    last_tap  = (({1'b0, cnt_q} + 9'd1) == {1'b0, fs_eff});
  end

  // Tap counter and per-window configuration latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      win_fs_q   <= 8'd1;
      win_mode_q <= PREC_16;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (fire) begin
      cnt_q <= last_tap ? 8'd0 : cnt_q + 8'd1;
      if (first_tap) begin
        win_fs_q   <= fs_req;
        win_mode_q <= mode_eff;
      end
    end
  end

  // Valid/tag pipeline matching the lane datapath, then accumulator and output stages
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      v_q         <= '0;
      first_q     <= '0;
      last_q      <= '0;
      for (int i = 0; i < MUL_LAT; i++) mode_q[i] <= PREC_16;
      acc_v_q     <= 1'b0;
      acc_last_q  <= 1'b0;
      acc_mode_q  <= PREC_16;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      v_q[0]     <= fire;
      first_q[0] <= first_tap;
      last_q[0]  <= last_tap;
      mode_q[0]  <= mode_eff;
      for (int i = 1; i < MUL_LAT; i++) begin
        v_q[i]     <= v_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        mode_q[i]  <= mode_q[i-1];
      end
      acc_v_q     <= v_q[MUL_LAT-1];
      acc_last_q  <= last_q[MUL_LAT-1];
      acc_mode_q  <= mode_q[MUL_LAT-1];
      out_valid_q <= acc_v_q && acc_last_q;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != 8'd0) || (|v_q) || acc_v_q || out_valid_q;

  for (genvar g = 0; g < NPX; g++) begin : g_lane
    hwce_sop_acc_lane #(
      .X_WIDTH  (X_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .MUL_LAT  (MUL_LAT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .en        (adv),
      .x         (x_in[g*X_WIDTH +: X_WIDTH]),
      .w         (w_in[g*X_WIDTH +: X_WIDTH]),
      .prod_valid(v_q[MUL_LAT-1]),
      .prod_first(first_q[MUL_LAT-1]),
      .out_load  (acc_v_q && acc_last_q),
      .out_mode  (acc_mode_q),
      .y         (y_out[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_hwce_sop_acc.sv
// tb/tb_hwce_sop_acc.sv - scoreboard bench for hwce_sop_acc
module tb_hwce_sop_acc;
  localparam int NPX = 4;
  localparam int XW  = 16;
  localparam int OW  = 32;
  localparam int ML  = 3;

  logic clk = 1'b0;
  logic rst, clear, precision8, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] fs_fs;
  logic [NPX*XW-1:0] x_in, w_in;
  logic [NPX*OW-1:0] y_out;

  int n_err = 0, n_chk = 0, cyc = 0, n_push = 0, n_pop = 0, accept_cyc = 0;
  logic [NPX*OW-1:0] exp_q[$];
  logic [NPX*XW-1:0] wx_q[$], ww_q[$];
  logic [NPX*OW-1:0] mon_e, held_y;
  bit stop_rand;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hwce_sop_acc #(.NPX(NPX), .X_WIDTH(XW), .ACC_WIDTH(48), .OUT_WIDTH(OW), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .clear(clear), .fs_fs(fs_fs), .precision8(precision8),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy));

  task automatic check(input string tag, input logic [NPX*OW-1:0] got, input logic [NPX*OW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] conv(input longint v, input int w);
    longint lim;
    lim = longint'(1) << (w - 1);
`ifdef HWCE_SOP_ACC_SAT_EN
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
`endif
    return v;
  endfunction

  function automatic logic [NPX*OW-1:0] model(input bit p8);
    logic [NPX*OW-1:0] e;
    logic [15:0] xv, wv;
    logic [63:0] r, rh, rl;
    longint a16, ah, al, bh, bl;
    e = '0;
    for (int l = 0; l < NPX; l++) begin
      a16 = 0; ah = 0; al = 0;
      for (int t = 0; t < wx_q.size(); t++) begin
        xv = wx_q[t][l*XW +: XW];
        wv = ww_q[t][l*XW +: XW];
        a16 += longint'($signed(xv)) * longint'($signed(wv));
        bh = (xv[15:8] == 8'h80) ? -127 : longint'($signed(xv[15:8]));
        bl = (xv[7:0] == 8'h80) ? -127 : longint'($signed(xv[7:0]));
        ah += bh * longint'($signed(wv[7:0]));
        al += bl * longint'($signed(wv[7:0]));
      end
      if (!p8) begin
        r = conv(a16, OW);
        e[l*OW +: OW] = r[OW-1:0];
      end else begin
        rh = conv(ah, OW/2);
        rl = conv(al, OW/2);
        e[l*OW +: OW] = {rh[OW/2-1:0], rl[OW/2-1:0]};
      end
    end
    return e;
  endfunction

  // Scoreboard side: every accepted output is compared with the oldest expected window
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        check("y_out", y_out, mon_e);
      end
      n_pop++;
    end
  end

  task automatic send_beat(input logic [NPX*XW-1:0] xv, input logic [NPX*XW-1:0] wv,
                           input int fs, input bit p8);
    bit rdy;
    rdy = 1'b0;
    x_in = xv; w_in = wv; fs_fs = 8'(fs); precision8 = p8; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    if (rdy) accept_cyc = cyc;
    else check("accept_timeout", rdy, 1'b1);
  endtask

  // Mode pin is flipped after the first tap to confirm the window keeps its latched mode
  task automatic send_window(input int n, input int fs_first, input int fs_rest, input bit p8);
    logic [NPX*OW-1:0] e;
    e = model(p8);
    for (int t = 0; t < n; t++)
      send_beat(wx_q[t], ww_q[t], (t == 0) ? fs_first : fs_rest, (t == 0) ? p8 : ~p8);
    exp_q.push_back(e);
    n_push++;
    wx_q.delete(); ww_q.delete();
    in_valid = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    logic [NPX*XW-1:0] xv;
    for (int t = 0; t < n; t++) begin
      xv = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) xv[7:0] = 8'h80;
      if ($urandom_range(0, 2) == 0) xv[XW+15 -: 8] = 8'h80;
      wx_q.push_back(xv);
      ww_q.push_back({$urandom, $urandom});
    end
  endtask

  task automatic fill_const(input int n, input logic [15:0] xv, input logic [15:0] wv);
    for (int t = 0; t < n; t++) begin
      wx_q.push_back({NPX{xv}});
      ww_q.push_back({NPX{wv}});
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit p8;
    logic [15:0] t1x[3], t1w[3];
    logic [NPX*XW-1:0] xv, wv;
    t1x = '{16'd100, -16'sd200, 16'd300};
    t1w = '{16'd2, 16'd3, -16'sd1};
    rst = 1'b1; clear = 1'b0; fs_fs = 8'd1; precision8 = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; x_in = '0; w_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y_out", y_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // 16-bit, 3 taps, lane0 fixed: latency and single-cycle pulse
    for (int t = 0; t < 3; t++) begin
      xv = {$urandom, $urandom}; wv = {$urandom, $urandom};
      xv[15:0] = t1x[t]; wv[15:0] = t1w[t];
      wx_q.push_back(xv); ww_q.push_back(wv);
    end
    send_window(3, 3, 3, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("t1_latency", 128'(cyc - accept_cyc), 128'(ML + 1));
    @(negedge clk);
    check("t1_pulse", out_valid, 1'b0);
    wait_idle();

    // packed 8-bit with -128 clamp, then a random 8-bit window
    fill_const(2, 16'h807F, 16'h1205);
    send_window(2, 2, 5, 1'b1);
    fill_rand(3);
    send_window(3, 3, 1, 1'b1);
    wait_idle();

    // backpressure: two single-tap windows, output held for 5 cycles
    out_ready = 1'b0;
    fill_rand(1); send_window(1, 1, 1, 1'b0);
    fill_rand(1); send_window(1, 1, 1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_first_valid", out_valid, 1'b1);
    held_y = y_out;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_y_hold", y_out, held_y);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_second_valid", out_valid, 1'b1);
    @(negedge clk);
    check("bp_drained", out_valid, 1'b0);
    wait_idle();

    // clear mid-window, with a simultaneous handshake discarded
    fill_rand(3);
    send_beat(wx_q[0], ww_q[0], 4, 1'b0);
    send_beat(wx_q[1], ww_q[1], 4, 1'b0);
    x_in = wx_q[2]; in_valid = 1'b1; clear = 1'b1;
    wx_q.delete(); ww_q.delete();
    @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clear_busy", busy, 1'b0);
    check("clear_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    fill_const(4, 16'd1, 16'd1);
    send_window(4, 4, 4, 1'b0);
    wait_idle();

    // fs_fs change mid-window is ignored until the next window
    fill_rand(4); send_window(4, 4, 2, 1'b0);
    fill_rand(2); send_window(2, 2, 7, 1'b0);
    // saturation / wrap corner and fs_fs=0 treated as 1
    fill_const(4, 16'h7FFF, 16'h7FFF); send_window(4, 4, 4, 1'b0);
    fill_rand(1); send_window(1, 0, 0, 1'b0);
    wait_idle();

    // random windows under random backpressure
    stop_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          n = $urandom_range(1, 4);
          p8 = 1'($urandom_range(0, 1));
          fill_rand(n);
          send_window(n, n, $urandom_range(0, 9), p8);
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join

    wait_idle();
    check("final_busy", busy, 1'b0);
    check("final_count", 128'(n_pop), 128'(n_push));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hwce_sop_acc.md
Name: hwce_sop_acc

Overview:
- Parametrised successor of the HWCE sum-of-products stage: NPX lanes, each a pipelined multiply-accumulate.
- Runtime precision mode: one 16x16 product per lane, or two packed 8x8 products per lane sharing one weight byte.
- Accumulates over a runtime window of fs_fs taps.
- Valid/ready handshake on both sides with full backpressure. Sits between the line-buffer/weight feeder and the HWCE output/normalisation stage.

Parameters:
- NPX, 4, number of lanes.
- X_WIDTH, 16, input/weight width per lane; even, >=8.
- ACC_WIDTH, 48, 16-bit-mode accumulator width; each 8-bit-mode half accumulator is ACC_WIDTH/2.
- OUT_WIDTH, 32, output width per lane; 8-bit mode packs two OUT_WIDTH/2 results.
- MUL_LAT, 3, product pipeline stages (DSP input/M registers), >=1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous flush of pipeline, counters and accumulators
- fs_fs  in  8  taps per window; 0 treated as 1
- precision8  in  1  1 = packed 8-bit mode, 0 = 16-bit mode
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- x_in  in  NPX*X_WIDTH  activations (8-bit mode: {hi,lo} bytes)
- w_in  in  NPX*X_WIDTH  weights (8-bit mode: low byte used)
- out_valid  out  1  window result valid
- out_ready  in  1  downstream accept
- y_out  out  NPX*OUT_WIDTH  per-lane window result
- busy  out  1  window open or data in flight

Behaviour:
- Reset: out_valid=0, y_out=0, busy=0, tap counter=0, accumulators=0, all pipeline valid bits=0. in_ready=1 in the first cycle after reset release.
- Advance signal adv = !(out_valid && !out_ready). in_ready = adv.
- When adv=0 the whole datapath and valid pipeline hold.
- fs_fs and precision8 are latched on the first tap of each window; mid-window changes are ignored until the next window.
- 16-bit mode: product = signed x * signed w (2*X_WIDTH bits), sign-extended to ACC_WIDTH.
- 8-bit mode, per lane: hi = x[15:8]*w[7:0], lo = x[7:0]*w[7:0], all signed; each accumulates separately in ACC_WIDTH/2.
- 8-bit mode operand clamp: any activation byte equal to -128 is replaced by -127 before the multiply. Weights are not clamped.
- Window accumulation: the first tap's product loads the accumulator (no add); subsequent taps add.
- Tap counter increments on each accepted beat and wraps to 0 after fs_fs taps.
- Last-tap result: when the last tap's product leaves the accumulator stage, the accumulator is copied to the output register and out_valid=1.
- Latency: if the last tap is accepted at edge e with no stall, out_valid is 1 from edge e+MUL_LAT+1.
- Stalls extend latency 1:1.
- Output format: 16-bit mode y = acc[OUT_WIDTH-1:0]; 8-bit mode y = {hi_acc[OUT_WIDTH/2-1:0], lo_acc[OUT_WIDTH/2-1:0]}. Both wrap on truncation (see Optional Feature).
- out_valid drops on the edge where out_ready=1. Back-to-back windows with out_ready=1 lose no cycles; the next window's first tap may be accepted while the previous window's taps are in flight.
- clear: next edge zeroes valid pipeline, tap counter, accumulators and out_valid. y_out holds its value. Has priority over a simultaneous input handshake, which is discarded. clear during a stall also discards the pending output.
- rst has priority over clear.
- busy = (tap counter != 0) || any pipeline valid || out_valid.
- fs_fs=1: every beat is a full window; output equals the single product.

Optional Feature:
- Macro HWCE_SOP_ACC_SAT_EN.
- Defined: output conversion saturates each result to the signed range of its field. 16-bit mode uses OUT_WIDTH; 8-bit mode uses OUT_WIDTH/2 for each half.
- Undefined: plain truncation (wrap), as above. Accumulators themselves always wrap at their own width.

Decomposition:
- Shared package hwce_sop_pkg holds:
  - typedef of the precision mode;
  - the clamp constants (-128 to -127);
  - the default widths X_WIDTH, ACC_WIDTH and OUT_WIDTH;
  - function sat_trunc(value, width), used by the output stage.
- One sub-module, hwce_sop_acc_lane: per-lane clamp, multiply pipeline (MUL_LAT, with enable), dual/single accumulator, and output conversion. It is instantiated NPX times.
- The top level owns the valid pipeline, tap counter, config latch and handshake.

Test Plan:
- 16-bit, fs_fs=3, NPX=4, lane0 taps x=(100,-200,300) with w=(2,3,-1), continuous, out_ready=1 -> lane0 y=-700; out_valid high exactly MUL_LAT+1 cycles after the 3rd accept, for 1 cycle.
- 8-bit, fs_fs=2, x=0x80_7F with w=0x??05 twice -> hi=-127*5*2=-1270, lo=127*5*2=1270; y={16'hFB0A,16'h04F6}.
- Backpressure: two windows with fs_fs=1, out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 throughout; the first y holds stable; the second result appears one cycle after out_ready rises; no beat lost or duplicated.
- clear asserted mid-window (after 2 of 4 taps), then a new 4-tap window with x=1, w=1 -> y=4; no stale contribution; busy=0 one cycle after clear.
- fs_fs changed from 4 to 2 after the first tap -> the window still closes after 4 taps; the next window uses 2.
- With HWCE_SOP_ACC_SAT_EN, 16-bit, fs_fs=4, x=32767, w=32767 -> y=0x7FFFFFFF. Without the macro, y=acc[31:0]=0xFFFC0004.
